// File: rtl/hasti_arbiter.sv
// Two-master to one-slave AHB-Lite (HASTI) arbiter with per-master holding
// registers for address phases that cannot be forwarded immediately.
module hasti_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_haddr,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [1:0]    m0_htrans,
    input  logic [DW-1:0] m0_hwdata,
    output logic [DW-1:0] m0_hrdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    input  logic [AW-1:0] m1_haddr,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [1:0]    m1_htrans,
    input  logic [DW-1:0] m1_hwdata,
    output logic [DW-1:0] m1_hrdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [AW-1:0] s_haddr,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [1:0]    s_htrans,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,
    input  logic          s_hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    function automatic owner_e owner_of(input logic idx);
        return idx ? OWN_M1 : OWN_M0;
    endfunction

    logic [AW-1:0] in_addr  [2];
    logic [1:0]    in_write;
    logic [2:0]    in_size  [2];
    logic [1:0]    in_trans [2];

    assign in_addr[0]  = m0_haddr;
    assign in_addr[1]  = m1_haddr;
    assign in_write    = {m1_hwrite, m0_hwrite};
    assign in_size[0]  = m0_hsize;
    assign in_size[1]  = m1_hsize;
    assign in_trans[0] = m0_htrans;
    assign in_trans[1] = m1_htrans;

    logic [1:0]    pend_q, pend_d;
    logic [AW-1:0] pend_addr_q  [2];
    logic [AW-1:0] pend_addr_d  [2];
    logic [1:0]    pend_write_q, pend_write_d;
    logic [2:0]    pend_size_q  [2];
    logic [2:0]    pend_size_d  [2];
    logic [1:0]    pend_trans_q [2];
    logic [1:0]    pend_trans_d [2];
    owner_e        downer_q, downer_d;
    logic          last_gnt_q, last_gnt_d;
    logic          src_q, src_d;

    logic [1:0] hready;
    logic [1:0] live;
    logic [1:0] cand;
    logic       gnt_vld;
    logic       gnt_idx;
    logic       src;

    // hready depends only on registered state and s_hready, never on the grant.
    always_comb begin
        hready = 2'b11;
        live   = 2'b00;
        cand   = 2'b00;
        for (int m = 0; m < 2; m++) begin
            if (pend_q[m]) begin
                hready[m] = 1'b0;
            end else if (downer_q == owner_of(m[0])) begin
                hready[m] = s_hready;
            end
            live[m] = in_trans[m][1] & hready[m] & ~reset;
            cand[m] = pend_q[m] | live[m];
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (s_hready && !reset) begin
            if (cand[0] && cand[1]) begin
                gnt_vld = 1'b1;
                gnt_idx = (FIXED_PRIO != 0) ? 1'b1 : ~last_gnt_q;
            end else if (cand[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end else if (cand[1]) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    assign src = gnt_vld ? gnt_idx : src_q;

    always_comb begin
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        s_htrans = HTRANS_IDLE;
        if (!reset) begin
            if (pend_q[src]) begin
                s_haddr  = pend_addr_q[src];
                s_hwrite = pend_write_q[src];
                s_hsize  = pend_size_q[src];
            end else begin
                s_haddr  = in_addr[src];
                s_hwrite = in_write[src];
                s_hsize  = in_size[src];
            end
            if (gnt_vld) begin
                s_htrans = pend_q[src] ? pend_trans_q[src] : in_trans[src];
            end
        end
    end

    always_comb begin
        s_hwdata = '0;
        m0_hresp = 1'b0;
        m1_hresp = 1'b0;
        case (downer_q)
            OWN_M0: begin
                s_hwdata = m0_hwdata;
                m0_hresp = s_hresp;
            end
            OWN_M1: begin
                s_hwdata = m1_hwdata;
                m1_hresp = s_hresp;
            end
            default: ;
        endcase
    end

    assign m0_hready = hready[0];
    assign m1_hready = hready[1];
    assign m0_hrdata = reset ? '0 : s_hrdata;
    assign m1_hrdata = reset ? '0 : s_hrdata;

    // A live request that is not granted this edge is parked; a granted
    // pending request is released. Both cannot hit the same master at once.
    always_comb begin
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        pend_size_d  = pend_size_q;
        pend_trans_d = pend_trans_q;
        downer_d     = downer_q;
        last_gnt_d   = last_gnt_q;
        src_d        = src;
        if (s_hready) begin
            downer_d = gnt_vld ? owner_of(gnt_idx) : OWN_NONE;
            if (gnt_vld) begin
                last_gnt_d      = gnt_idx;
                pend_d[gnt_idx] = 1'b0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (live[m] && !(gnt_vld && gnt_idx == m[0])) begin
                pend_d[m]       = 1'b1;
                pend_addr_d[m]  = in_addr[m];
                pend_write_d[m] = in_write[m];
                pend_size_d[m]  = in_size[m];
                pend_trans_d[m] = in_trans[m];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= '0;
            pend_write_q <= '0;
            for (int m = 0; m < 2; m++) begin
                pend_addr_q[m]  <= '0;
                pend_size_q[m]  <= '0;
                pend_trans_q[m] <= HTRANS_IDLE;
            end
            downer_q   <= OWN_NONE;
            last_gnt_q <= 1'b1;
            src_q      <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            pend_size_q  <= pend_size_d;
            pend_trans_q <= pend_trans_d;
            downer_q     <= downer_d;
            last_gnt_q   <= last_gnt_d;
            src_q        <= src_d;
        end
    end

endmodule

// File: tb/tb_hasti_arbiter.sv
// Self-checking bench for hasti_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_hasti_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_haddr  [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize  [2];
    logic [1:0]  m_htrans [2];
    logic [31:0] m_hwdata [2];
    logic [31:0] m_hrdata [2];
    logic        m_hready [2];
    logic        m_hresp  [2];
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hasti_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_haddr(m_haddr[0]), .m0_hwrite(m_hwrite[0]), .m0_hsize(m_hsize[0]),
        .m0_htrans(m_htrans[0]), .m0_hwdata(m_hwdata[0]), .m0_hrdata(m_hrdata[0]),
        .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]),
        .m1_haddr(m_haddr[1]), .m1_hwrite(m_hwrite[1]), .m1_hsize(m_hsize[1]),
        .m1_htrans(m_htrans[1]), .m1_hwdata(m_hwdata[1]), .m1_hrdata(m_hrdata[1]),
        .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_htrans(s_htrans),
        .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    // Reference model: per-master waiting request, data-phase owner, last winner.
    bit          w_valid [2];
    logic [31:0] w_addr  [2];
    logic        w_write [2];
    logic [2:0]  w_size  [2];
    int          owner;
    int          last_winner;
    int          winner;
    bit          accepted [2];
    bit          sb_en;
    logic [31:0] sb_q0 [$];
    logic [31:0] sb_q1 [$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) w_valid[m] = 0;
        owner = -1;
        last_winner = 1;
        sb_q0.delete();
        sb_q1.delete();
    endtask

    task automatic setMaster(input int m, input logic [1:0] tr, input logic [31:0] a,
                             input logic w, input logic [31:0] d);
        m_htrans[m] = tr;
        m_haddr[m]  = a;
        m_hwrite[m] = w;
        m_hsize[m]  = 3'b010;
        m_hwdata[m] = d;
    endtask

    task automatic applyStimulus(input logic rdy, input logic resp, input logic [31:0] rdata);
        s_hready = rdy;
        s_hresp  = resp;
        s_hrdata = rdata;
    endtask

    // Predict and compare every output a few ns after inputs settle.
    task automatic sampleAndCheck();
        bit want [2];
        int ready_exp [2];
        logic [31:0] front;
        #3;
        for (int m = 0; m < 2; m++) begin
            if (w_valid[m]) ready_exp[m] = 0;
            else if (owner == m) ready_exp[m] = int'(s_hready);
            else ready_exp[m] = 1;
            accepted[m] = (m_htrans[m] == 2'b10) && (ready_exp[m] == 1);
            want[m] = w_valid[m] || accepted[m];
        end
        winner = -1;
        if (s_hready) begin
            if (want[0] && want[1]) winner = (last_winner == 0) ? 1 : 0;
            else if (want[0]) winner = 0;
            else if (want[1]) winner = 1;
        end
        checkOutput("m0_hready", 64'(m_hready[0]), 64'(ready_exp[0]));
        checkOutput("m1_hready", 64'(m_hready[1]), 64'(ready_exp[1]));
        checkOutput("s_htrans", 64'(s_htrans), (winner >= 0) ? 64'h2 : 64'h0);
        if (winner >= 0) begin
            checkOutput("s_haddr", 64'(s_haddr), 64'(w_valid[winner] ? w_addr[winner] : m_haddr[winner]));
            checkOutput("s_hwrite", 64'(s_hwrite), 64'(w_valid[winner] ? w_write[winner] : m_hwrite[winner]));
            checkOutput("s_hsize", 64'(s_hsize), 64'(w_valid[winner] ? w_size[winner] : m_hsize[winner]));
        end
        checkOutput("s_hwdata", 64'(s_hwdata), (owner < 0) ? 64'h0 : 64'(m_hwdata[owner]));
        checkOutput("m0_hresp", 64'(m_hresp[0]), (owner == 0) ? 64'(s_hresp) : 64'h0);
        checkOutput("m1_hresp", 64'(m_hresp[1]), (owner == 1) ? 64'(s_hresp) : 64'h0);
        checkOutput("m0_hrdata", 64'(m_hrdata[0]), 64'(s_hrdata));
        checkOutput("m1_hrdata", 64'(m_hrdata[1]), 64'(s_hrdata));
        if (sb_en) begin
            if (accepted[0]) sb_q0.push_back(m_haddr[0]);
            if (accepted[1]) sb_q1.push_back(m_haddr[1]);
            if (s_htrans == 2'b10 && s_hready) begin
                if (s_haddr[31]) begin
                    checkOutput("sb_m1_nonempty", 64'(sb_q1.size() > 0), 64'h1);
                    if (sb_q1.size() > 0) begin
                        front = sb_q1.pop_front();
                        checkOutput("sb_m1_order", 64'(s_haddr), 64'(front));
                    end
                end else begin
                    checkOutput("sb_m0_nonempty", 64'(sb_q0.size() > 0), 64'h1);
                    if (sb_q0.size() > 0) begin
                        front = sb_q0.pop_front();
                        checkOutput("sb_m0_order", 64'(s_haddr), 64'(front));
                    end
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (s_hready) begin
            owner = winner;
            if (winner >= 0) begin
                last_winner = winner;
                w_valid[winner] = 0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (accepted[m] && winner != m) begin
                w_valid[m] = 1;
                w_addr[m]  = m_haddr[m];
                w_write[m] = m_hwrite[m];
                w_size[m]  = m_hsize[m];
            end
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        setMaster(0, 2'b00, 32'h0, 1'b0, 32'h0);
        setMaster(1, 2'b00, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        sb_en = 0;
        resetDut();

        // Uncontended read forwarded in the same cycle.
        setMaster(0, 2'b10, 32'h100, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        sampleAndCheck();
        checkOutput("t1_haddr", 64'(s_haddr), 64'h100);
        checkOutput("t1_htrans", 64'(s_htrans), 64'h2);
        advance();
        setMaster(0, 2'b00, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
        sampleAndCheck();
        checkOutput("t1_rdata", 64'(m_hrdata[0]), 64'hDEADBEEF);
        checkOutput("t1_m1_ready", 64'(m_hready[1]), 64'h1);
        advance();

        // Simultaneous requests after reset: m0 first, m1 parked.
        resetDut();
        setMaster(0, 2'b10, 32'h10, 1'b0, 32'h0);
        setMaster(1, 2'b10, 32'h20, 1'b1, 32'h0);
        sampleAndCheck();
        checkOutput("t2_first_addr", 64'(s_haddr), 64'h10);
        advance();
        setMaster(0, 2'b00, 32'h0, 1'b0, 32'h0);
        sampleAndCheck();
        checkOutput("t2_m1_stalled", 64'(m_hready[1]), 64'h0);
        checkOutput("t2_second_addr", 64'(s_haddr), 64'h20);
        checkOutput("t2_second_write", 64'(s_hwrite), 64'h1);
        advance();
        setMaster(1, 2'b00, 32'h0, 1'b0, 32'h55);
        sampleAndCheck();
        checkOutput("t2_wdata", 64'(s_hwdata), 64'h55);
        checkOutput("t2_m1_ready", 64'(m_hready[1]), 64'h1);
        advance();

        // Back-to-back contention: grants alternate, scoreboard tracks order.
        resetDut();
        sb_en = 1;
        for (int i = 0; i < 6; i++) begin
            setMaster(0, 2'b10, 32'h0000_1000 + 32'(i * 4), 1'b0, 32'h0);
            setMaster(1, 2'b10, 32'h8000_2000 + 32'(i * 4), 1'b0, 32'h0);
            sampleAndCheck();
            checkOutput("t3_alternate", 64'(s_haddr[31]), 64'(i % 2));
            advance();
        end
        sb_en = 0;

        // Slave wait states while m1 owns the data phase.
        resetDut();
        setMaster(1, 2'b10, 32'h80, 1'b0, 32'h0);
        sampleAndCheck();
        advance();
        setMaster(1, 2'b00, 32'h0, 1'b0, 32'h0);
        setMaster(0, 2'b10, 32'h40, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            sampleAndCheck();
            checkOutput("t4_m1_wait", 64'(m_hready[1]), 64'h0);
            if (i > 0) checkOutput("t4_m0_held", 64'(m_hready[0]), 64'h0);
            advance();
        end
        setMaster(0, 2'b00, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        sampleAndCheck();
        checkOutput("t4_addr", 64'(s_haddr), 64'h40);
        checkOutput("t4_htrans", 64'(s_htrans), 64'h2);
        advance();

        // Two-cycle ERROR to m1.
        resetDut();
        setMaster(1, 2'b10, 32'h90, 1'b0, 32'h0);
        sampleAndCheck();
        advance();
        setMaster(1, 2'b00, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        sampleAndCheck();
        checkOutput("t5_err1", 64'(m_hresp[1]), 64'h1);
        checkOutput("t5_m0_ok1", 64'(m_hresp[0]), 64'h0);
        advance();
        applyStimulus(1'b1, 1'b1, 32'h0);
        sampleAndCheck();
        checkOutput("t5_err2", 64'(m_hresp[1]), 64'h1);
        checkOutput("t5_m0_ok2", 64'(m_hresp[0]), 64'h0);
        advance();

        // Reset mid-operation: m0 in data phase, m1 pending.
        resetDut();
        setMaster(0, 2'b10, 32'h300, 1'b0, 32'h0);
        setMaster(1, 2'b10, 32'h400, 1'b0, 32'h0);
        sampleAndCheck();
        advance();
        applyStimulus(1'b0, 1'b0, 32'h1234);
        reset = 1'b1;
        #1;
        checkOutput("t6_htrans", 64'(s_htrans), 64'h0);
        checkOutput("t6_m0_ready", 64'(m_hready[0]), 64'h1);
        checkOutput("t6_m1_ready", 64'(m_hready[1]), 64'h1);
        checkOutput("t6_haddr", 64'(s_haddr), 64'h0);
        checkOutput("t6_rdata", 64'(m_hrdata[0]), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        sampleAndCheck();
        checkOutput("t6_first_tie", 64'(s_haddr), 64'h300);
        advance();

        // Randomized traffic with a reset in the middle.
        resetDut();
        sb_en = 1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                resetDut();
            end
            for (int m = 0; m < 2; m++) begin
                setMaster(m, ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b00,
                          {m[0], 31'($urandom)}, 1'($urandom), $urandom);
                m_hsize[m] = 3'($urandom_range(0, 2));
            end
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, $urandom);
            sampleAndCheck();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
